// File: rtl/lsu_pkg.sv
// Shared definitions for the NPC load/store stage: mem_op codes, FSM state encodings and op decode.
package lsu_pkg;

  localparam logic [3:0] OpNone = 4'd0;
  localparam logic [3:0] OpLb   = 4'd1;
  localparam logic [3:0] OpLh   = 4'd2;
  localparam logic [3:0] OpLw   = 4'd3;
  localparam logic [3:0] OpLbu  = 4'd4;
  localparam logic [3:0] OpLhu  = 4'd5;
  localparam logic [3:0] OpSb   = 4'd9;
  localparam logic [3:0] OpSh   = 4'd10;
  localparam logic [3:0] OpSw   = 4'd11;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  typedef struct packed {
    logic  is_load;
    logic  is_store;
    size_e size;
    logic  sext;
  } op_dec_t;

  // Unlisted codes decode as NONE (neither load nor store).
  function automatic op_dec_t decode_op(input logic [3:0] op);
    op_dec_t d;
    d = '{is_load: 1'b0, is_store: 1'b0, size: SzWord, sext: 1'b0};
    case (op)
      OpLb:    d = '{is_load: 1'b1, is_store: 1'b0, size: SzByte, sext: 1'b1};
      OpLh:    d = '{is_load: 1'b1, is_store: 1'b0, size: SzHalf, sext: 1'b1};
      OpLw:    d = '{is_load: 1'b1, is_store: 1'b0, size: SzWord, sext: 1'b0};
      OpLbu:   d = '{is_load: 1'b1, is_store: 1'b0, size: SzByte, sext: 1'b0};
      OpLhu:   d = '{is_load: 1'b1, is_store: 1'b0, size: SzHalf, sext: 1'b0};
      OpSb:    d = '{is_load: 1'b0, is_store: 1'b1, size: SzByte, sext: 1'b0};
      OpSh:    d = '{is_load: 1'b0, is_store: 1'b1, size: SzHalf, sext: 1'b0};
      OpSw:    d = '{is_load: 1'b0, is_store: 1'b1, size: SzWord, sext: 1'b0};
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic is_misaligned(input op_dec_t d, input logic [1:0] a);
    return (d.is_load || d.is_store) &&
           (((d.size == SzHalf) && a[0]) || ((d.size == SzWord) && (a != 2'b00)));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobe/data replication and load extract with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_result
);

  op_dec_t     dec;
  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  always_comb begin
    dec         = decode_op(op);
    byte_sh     = load_word >> {addr_lo, 3'b000};
    half_sh     = load_word >> {addr_lo[1], 4'b0000};
    wstrb       = 4'b0000;
    wdata       = store_data;
    load_result = load_word;
    unique case (dec.size)
      SzByte: begin
        wstrb       = 4'b0001 << addr_lo;
        wdata       = {4{store_data[7:0]}};
        load_result = {{24{dec.sext & byte_sh[7]}}, byte_sh[7:0]};
      end
      SzHalf: begin
        wstrb       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata       = {2{store_data[15:0]}};
        load_result = {{16{dec.sext & half_sh[15]}}, half_sh[15:0]};
      end
      default: begin
        wstrb       = 4'b1111;
        wdata       = store_data;
        load_result = load_word;
      end
    endcase
    // Strobes only mean something on a write.
    if (!dec.is_store) wstrb = 4'b0000;
  end

endmodule

// File: rtl/lsu.sv
// NPC load/store stage: one instruction in flight, IDLE -> REQ -> WAIT -> DONE.
// Optional LSU_MISALIGN_CHECK_EN adds out_misalign and skips the bus for misaligned accesses.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] ex_result,
  input  logic [DATA_W-1:0] rs2_value,
  input  logic [3:0]        mem_op,
  input  logic [4:0]        rd_addr,
  input  logic              rd_wen,
  input  logic [ADDR_W-1:0] pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [3:0]        mem_req_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [4:0]        out_rd_addr,
  output logic              out_rd_wen,
  output logic [ADDR_W-1:0] out_pc
`ifdef LSU_MISALIGN_CHECK_EN
  , output logic            out_misalign
`endif
);

  logic [1:0]        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              req_valid_q, req_valid_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_wen_q, req_wen_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [3:0]        req_wstrb_q, req_wstrb_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [4:0]        out_rd_addr_q, out_rd_addr_d;
  logic              out_rd_wen_q, out_rd_wen_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
`ifdef LSU_MISALIGN_CHECK_EN
  logic              misalign_q, misalign_d;
`endif

  op_dec_t     in_dec;
  op_dec_t     cur_dec;
  logic [3:0]  align_op;
  logic [1:0]  align_addr;
  logic [3:0]  align_wstrb;
  logic [31:0] align_wdata;
  logic [31:0] align_load;

  // In IDLE the aligner sees the incoming op so the request can be registered at capture.
  assign align_op   = (state_q == StIdle) ? mem_op : op_q;
  assign align_addr = (state_q == StIdle) ? ex_result[1:0] : addr_lo_q;

  lsu_align u_align (
    .op          (align_op),
    .addr_lo     (align_addr),
    .store_data  (rs2_value),
    .load_word   (mem_rsp_rdata),
    .wstrb       (align_wstrb),
    .wdata       (align_wdata),
    .load_result (align_load)
  );

  always_comb begin
    in_dec        = decode_op(mem_op);
    cur_dec       = decode_op(op_q);
    state_d       = state_q;
    op_d          = op_q;
    addr_lo_d     = addr_lo_q;
    req_valid_d   = req_valid_q;
    req_addr_d    = req_addr_q;
    req_wen_d     = req_wen_q;
    req_wdata_d   = req_wdata_q;
    req_wstrb_d   = req_wstrb_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_rd_addr_d = out_rd_addr_q;
    out_rd_wen_d  = out_rd_wen_q;
    out_pc_d      = out_pc_q;
`ifdef LSU_MISALIGN_CHECK_EN
    misalign_d    = misalign_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d          = mem_op;
          addr_lo_d     = ex_result[1:0];
          out_rd_addr_d = rd_addr;
          out_pc_d      = pc;
`ifdef LSU_MISALIGN_CHECK_EN
          misalign_d    = 1'b0;
`endif
          if (!in_dec.is_load && !in_dec.is_store) begin
            out_result_d = ex_result;
            out_rd_wen_d = rd_wen;
            out_valid_d  = 1'b1;
            state_d      = StDone;
`ifdef LSU_MISALIGN_CHECK_EN
          end else if (is_misaligned(in_dec, ex_result[1:0])) begin
            out_result_d = ex_result;
            out_rd_wen_d = 1'b0;
            misalign_d   = 1'b1;
            out_valid_d  = 1'b1;
            state_d      = StDone;
`endif
          end else begin
            req_valid_d  = 1'b1;
            req_addr_d   = {ex_result[ADDR_W-1:2], 2'b00};
            req_wen_d    = in_dec.is_store;
            req_wdata_d  = align_wdata;
            req_wstrb_d  = align_wstrb;
            out_rd_wen_d = in_dec.is_store ? 1'b0 : rd_wen;
            state_d      = StReq;
          end
        end
      end
      StReq: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (mem_rsp_valid) begin
          out_result_d = cur_dec.is_store ? '0 : align_load;
          out_valid_d  = 1'b1;
          state_d      = StDone;
        end
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      op_q          <= OpNone;
      addr_lo_q     <= '0;
      req_valid_q   <= 1'b0;
      req_addr_q    <= '0;
      req_wen_q     <= 1'b0;
      req_wdata_q   <= '0;
      req_wstrb_q   <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_rd_addr_q <= '0;
      out_rd_wen_q  <= 1'b0;
      out_pc_q      <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_lo_q     <= addr_lo_d;
      req_valid_q   <= req_valid_d;
      req_addr_q    <= req_addr_d;
      req_wen_q     <= req_wen_d;
      req_wdata_q   <= req_wdata_d;
      req_wstrb_q   <= req_wstrb_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_rd_addr_q <= out_rd_addr_d;
      out_rd_wen_q  <= out_rd_wen_d;
      out_pc_q      <= out_pc_d;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

  assign in_ready      = (state_q == StIdle) && !rst;
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wen   = req_wen_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wstrb = req_wstrb_q;
  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_rd_addr   = out_rd_addr_q;
  assign out_rd_wen    = out_rd_wen_q;
  assign out_pc        = out_pc_q;
`ifdef LSU_MISALIGN_CHECK_EN
  assign out_misalign  = misalign_q;
`endif

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: hand-computed vectors, immediate assertions at each check point.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ex_result;
  logic [31:0] rs2_value;
  logic [3:0]  mem_op;
  logic [4:0]  rd_addr;
  logic        rd_wen;
  logic [31:0] pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd_addr;
  logic        out_rd_wen;
  logic [31:0] out_pc;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        out_misalign;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ex_result     (ex_result),
    .rs2_value     (rs2_value),
    .mem_op        (mem_op),
    .rd_addr       (rd_addr),
    .rd_wen        (rd_wen),
    .pc            (pc),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_rd_addr   (out_rd_addr),
    .out_rd_wen    (out_rd_wen),
    .out_pc        (out_pc)
`ifdef LSU_MISALIGN_CHECK_EN
    , .out_misalign (out_misalign)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] ex, input logic [31:0] rs2);
    in_valid  = 1'b1;
    mem_op    = op;
    ex_result = ex;
    rs2_value = rs2;
    step();
    in_valid  = 1'b0;
  endtask

  // Request accepted at the next edge, response delivered at the one after.
  task automatic bus_zero_wait(input logic [31:0] rdata);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = rdata;
    step();
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    ex_result     = '0;
    rs2_value     = '0;
    mem_op        = 4'd0;
    rd_addr       = 5'd5;
    rd_wen        = 1'b1;
    pc            = 32'h0000_0100;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    out_ready     = 1'b1;
    step();
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // NONE: pass-through, out_valid one cycle after accept
    issue(4'd0, 32'h1234_5678, 32'h0);
    chk("none_out_valid", {31'd0, out_valid}, 32'd1);
    chk("none_result", out_result, 32'h1234_5678);
    chk("none_rd_wen", {31'd0, out_rd_wen}, 32'd1);
    chk("none_rd_addr", {27'd0, out_rd_addr}, 32'd5);
    chk("none_pc", out_pc, 32'h0000_0100);
    chk("none_no_req", {31'd0, mem_req_valid}, 32'd0);
    chk("none_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("none_retired", {31'd0, out_valid}, 32'd0);
    chk("none_back_idle", {31'd0, in_ready}, 32'd1);

    // Unlisted op code behaves as NONE
    issue(4'd7, 32'hCAFE_0001, 32'h0);
    chk("op7_result", out_result, 32'hCAFE_0001);
    chk("op7_no_req", {31'd0, mem_req_valid}, 32'd0);
    step();

    // LB at byte 3, sign-extended
    pc = 32'h0000_0200;
    issue(4'd1, 32'h8000_0003, 32'h0);
    chk("lb_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("lb_req_addr", mem_req_addr, 32'h8000_0000);
    chk("lb_req_wen", {31'd0, mem_req_wen}, 32'd0);
    bus_zero_wait(32'h80FF_0000);
    chk("lb_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lb_result", out_result, 32'hFFFF_FF80);
    chk("lb_pc", out_pc, 32'h0000_0200);
    step();

    // LBU same access, zero-extended
    issue(4'd4, 32'h8000_0003, 32'h0);
    bus_zero_wait(32'h80FF_0000);
    chk("lbu_result", out_result, 32'h0000_0080);
    step();

    // LH upper half, sign-extended; low address bit ignored for lane select
    issue(4'd2, 32'h8000_0002, 32'h0);
    bus_zero_wait(32'h8001_1234);
    chk("lh_result", out_result, 32'hFFFF_8001);
    step();

    // LHU lower half
    issue(4'd5, 32'h8000_0000, 32'h0);
    bus_zero_wait(32'h8001_9234);
    chk("lhu_result", out_result, 32'h0000_9234);
    step();

    // SH upper lanes
    issue(4'd10, 32'h8000_0002, 32'hAAAA_BEEF);
    chk("sh_wstrb", {28'd0, mem_req_wstrb}, 32'h0000_000C);
    chk("sh_wdata", mem_req_wdata, 32'hBEEF_BEEF);
    chk("sh_wen", {31'd0, mem_req_wen}, 32'd1);
    chk("sh_addr", mem_req_addr, 32'h8000_0000);
    bus_zero_wait(32'h5555_5555);
    chk("sh_result", out_result, 32'h0);
    chk("sh_rd_wen", {31'd0, out_rd_wen}, 32'd0);
    step();

    // SB at byte 1
    issue(4'd9, 32'h8000_0041, 32'h0000_125A);
    chk("sb_wstrb", {28'd0, mem_req_wstrb}, 32'h0000_0002);
    chk("sb_wdata", mem_req_wdata, 32'h5A5A_5A5A);
    chk("sb_addr", mem_req_addr, 32'h8000_0040);
    bus_zero_wait(32'h0);
    step();

    // SW
    issue(4'd11, 32'h8000_0008, 32'h0BAD_F00D);
    chk("sw_wstrb", {28'd0, mem_req_wstrb}, 32'h0000_000F);
    chk("sw_wdata", mem_req_wdata, 32'h0BAD_F00D);
    bus_zero_wait(32'h0);
    step();

    // LW with request and write-back back-pressure
    out_ready = 1'b0;
    issue(4'd3, 32'h8000_0010, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("lw_bp_req_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("lw_bp_req_addr", mem_req_addr, 32'h8000_0010);
      chk("lw_bp_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    bus_zero_wait(32'hDEAD_BEEF);
    for (int i = 0; i < 2; i++) begin
      chk("lw_bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("lw_bp_result", out_result, 32'hDEAD_BEEF);
      chk("lw_bp_in_ready2", {31'd0, in_ready}, 32'd0);
      step();
    end
    chk("lw_bp_still_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("lw_bp_retired", {31'd0, out_valid}, 32'd0);

    // Reset in WAIT, then a stray response
    issue(4'd3, 32'h8000_0020, 32'h0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_wait_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("rst_wait_out_result", out_result, 32'h0);
    chk("rst_wait_req_addr", mem_req_addr, 32'h0);
    chk("rst_wait_out_pc", out_pc, 32'h0);
    rst           = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h1111_2222;
    #1;
    chk("rst_wait_idle", {31'd0, in_ready}, 32'd1);
    step();
    mem_rsp_valid = 1'b0;
    chk("rst_stray_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stray_result", out_result, 32'h0);
    step();
    chk("rst_stray_out_valid2", {31'd0, out_valid}, 32'd0);
    chk("rst_stray_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef LSU_MISALIGN_CHECK_EN
    // Misaligned LW completes without a bus request
    issue(4'd3, 32'h8000_0002, 32'h0);
    chk("mis_no_req", {31'd0, mem_req_valid}, 32'd0);
    chk("mis_out_valid", {31'd0, out_valid}, 32'd1);
    chk("mis_flag", {31'd0, out_misalign}, 32'd1);
    chk("mis_rd_wen", {31'd0, out_rd_wen}, 32'd0);
    chk("mis_result", out_result, 32'h8000_0002);
    step();
    issue(4'd3, 32'h8000_0004, 32'h0);
    chk("mis_aligned_flag", {31'd0, out_misalign}, 32'd0);
    chk("mis_aligned_req", {31'd0, mem_req_valid}, 32'd1);
    bus_zero_wait(32'h0);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store stage of the NPC core, directly downstream of the execute stage. It takes the execute result as the effective address (or as a pass-through value for non-memory instructions), issues at most one request on a simple valid/ready memory bus, aligns and sign- or zero-extends load data, and hands the result to write-back through a valid/ready handshake. There is exactly one instruction in flight.

## Interface
Parameters:
- ADDR_W, 32, address width; must be 32.
- DATA_W, 32, data width; must be 32.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  execute-stage output valid.
- in_ready  out  1  LSU can accept an instruction.
- ex_result  in  32  execute result; effective address for memory ops.
- rs2_value  in  32  store data.
- mem_op  in  4  memory operation code.
- rd_addr  in  5  destination register.
- rd_wen  in  1  register write enable.
- pc  in  32  instruction PC, carried through.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus accepts request.
- mem_req_addr  out  32  word address, {addr[31:2],2'b00}.
- mem_req_wen  out  1  1 = store.
- mem_req_wdata  out  32  lane-shifted store data.
- mem_req_wstrb  out  4  byte strobes.
- mem_rsp_valid  in  1  response valid; read data or store acknowledge.
- mem_rsp_rdata  in  32  read word.
- out_valid  out  1  result valid to write-back.
- out_ready  in  1  write-back accepts.
- out_result  out  32  write-back value.
- out_rd_addr  out  5  destination register.
- out_rd_wen  out  1  write enable; forced to 0 for stores.
- out_pc  out  32  carried PC.
- out_misalign  out  1  misaligned access flag; present only with the macro.

## Operation
- mem_op encoding: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 9 SB, 10 SH, 11 SW. Any other value is treated as NONE.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture all inputs. Go to DONE if NONE, otherwise to REQ.
  - REQ: mem_req_valid=1 with request fields held stable. On mem_req_ready, go to WAIT.
  - WAIT: on mem_rsp_valid, capture the aligned load data (or a zero result for stores), then go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- NONE: out_result = ex_result.
- Stores: out_result = 0 and out_rd_wen = 0.
- Store lanes, with a = addr[1:0]:
  - SB: wstrb = 4'b0001<<a; wdata = {4{rs2[7:0]}}.
  - SH: wstrb = 4'b0011<<(a[1]*2); wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 4'b1111; wdata = rs2.
- Load extract:
  - Byte: rdata >> (8*a).
  - Half: rdata >> (16*a[1]).
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Low address bits not used for lane selection are ignored.
- mem_rsp_valid outside WAIT is ignored. The bus must not respond in the same cycle its request is accepted.

## Timing
- Reset (rst high at an edge): state becomes IDLE and every output register clears to 0. in_ready is forced to 0 while rst is high.
- Reset mid-transaction abandons the instruction. A response arriving later is ignored.
- Handshakes fire on valid&&ready at the clock edge.
- mem_req_* and out_* are registered and stay stable until their handshake completes.
- Latency for NONE: accepted at edge T, out_valid from T+1.
- Latency for memory ops: accepted at T, mem_req_valid from T+1. With ready at T+1 and the response at T+2, out_valid is high from T+3.
- Back-to-back throughput: NONE takes 2 cycles per instruction; a zero-wait memory op takes 4.
- Back-pressure: out_valid is held high across cycles where out_ready=0, with no state change.

## Configuration
- LSU_MISALIGN_CHECK_EN defined:
  - Misaligned accesses are LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]≠0.
  - A misaligned access goes IDLE→DONE without issuing a bus request.
  - It completes with out_misalign=1, out_rd_wen=0 and out_result=ex_result.
  - out_misalign is otherwise 0 and clears on reset.
- LSU_MISALIGN_CHECK_EN undefined:
  - The out_misalign port is absent.
  - Misaligned accesses proceed using the lane rules above.

## Structure
- The mem_op codes and FSM state encodings go in the shared para header, with the codebase suffix.
- One combinational sub-module, lsu_align: store strobe and data shifting, plus load extract and extension.
- The FSM and all registers stay in lsu.

## Test plan
- NONE, ex_result=0x1234_5678 → out_valid at T+1 with out_result=0x1234_5678 and out_rd_wen unchanged.
- LB at addr 0x8000_0003, rdata=0x80FF_0000 → mem_req_addr=0x8000_0000 and out_result=0xFFFF_FF80. The same access as LBU gives 0x0000_0080.
- SH at addr 0x8000_0002, rs2=0xAAAA_BEEF → wstrb=4'b1100, wdata=0xBEEF_BEEF, mem_req_wen=1, out_rd_wen=0.
- LW with mem_req_ready low for 3 cycles and out_ready low for 2 cycles → request fields and out_* held stable; in_ready=0 throughout.
- rst asserted in WAIT, then a stray mem_rsp_valid arrives → all outputs 0, in_ready=1 after reset, and no out_valid is produced.
- With LSU_MISALIGN_CHECK_EN, LW at 0x8000_0002 → no mem_req_valid; out_misalign=1 and out_rd_wen=0 at T+1.
